// File: rtl/bus_demux_1x2.sv
// ----------------------------------------------------------------------------
// bus_demux_1x2
//   One-to-two request router. A single load/store request from the core is
//   latched, decoded by address and forwarded to target A (data memory) or
//   target B (MMIO). The selected target's response is returned upstream as a
//   one-cycle pulse. Only one transaction is in flight at a time. A response
//   timeout produces an error response, so a dead target cannot hang the core.
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   req_valid_i / req_ready_o     core request handshake
//   req_addr_i, req_wdata_i,
//   req_we_i, req_wstrb_i         core request payload
//   resp_valid_o                  one-cycle response pulse to core
//   resp_rdata_o, resp_err_o      response data / timeout flag (held until next)
//   t_addr_o, t_wdata_o,
//   t_we_o, t_wstrb_o             latched request, broadcast to both targets
//   a_valid_o / a_ready_i         target A request handshake
//   a_rvalid_i, a_rdata_i         target A response
//   b_valid_o / b_ready_i         target B request handshake
//   b_rvalid_i, b_rdata_i         target B response
// ----------------------------------------------------------------------------
module bus_demux_1x2 #(
    parameter int             N       = 32,
    parameter logic [N-1:0]   B_BASE  = 32'h0000_8000,
    parameter logic [N-1:0]   B_MASK  = 32'hFFFF_8000,
    parameter int             TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [N-1:0]     req_addr_i,
    input  logic [N-1:0]     req_wdata_i,
    input  logic             req_we_i,
    input  logic [N/8-1:0]   req_wstrb_i,
    output logic             resp_valid_o,
    output logic [N-1:0]     resp_rdata_o,
    output logic             resp_err_o,
    output logic [N-1:0]     t_addr_o,
    output logic [N-1:0]     t_wdata_o,
    output logic             t_we_o,
    output logic [N/8-1:0]   t_wstrb_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    input  logic             a_rvalid_i,
    input  logic [N-1:0]     a_rdata_i,
    output logic             b_valid_o,
    input  logic             b_ready_i,
    input  logic             b_rvalid_i,
    input  logic [N-1:0]     b_rdata_i
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LIM   = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;       // 1 = target B
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [N-1:0]       addr_q, addr_d;
    logic [N-1:0]       wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [N/8-1:0]     wstrb_q, wstrb_d;

    logic hit_b;
    logic tgt_ready;
    logic tgt_rvalid;
    logic [N-1:0] tgt_rdata;

    assign hit_b      = ((req_addr_i & B_MASK) == B_BASE);
    assign tgt_ready  = sel_q ? b_ready_i  : a_ready_i;
    assign tgt_rvalid = sel_q ? b_rvalid_i : a_rvalid_i;
    assign tgt_rdata  = sel_q ? b_rdata_i  : a_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    we_d    = req_we_i;
                    wstrb_d = req_wstrb_i;
                    sel_d   = hit_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tgt_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real response beats a timeout landing in the same cycle.
                if (tgt_rvalid) begin
                    rdata_d = tgt_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LIM) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign a_valid_o    = (state_q == S_ISSUE) && !sel_q;
    assign b_valid_o    = (state_q == S_ISSUE) &&  sel_q;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign t_addr_o     = addr_q;
    assign t_wdata_o    = wdata_q;
    assign t_we_o       = we_q;
    assign t_wstrb_o    = wstrb_q;

endmodule

// File: tb/tb_bus_demux_1x2.sv
module tb_bus_demux_1x2;

    localparam int N = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [N-1:0]  req_addr_i;
    logic [N-1:0]  req_wdata_i;
    logic          req_we_i;
    logic [3:0]    req_wstrb_i;
    logic          resp_valid_o;
    logic [N-1:0]  resp_rdata_o;
    logic          resp_err_o;
    logic [N-1:0]  t_addr_o;
    logic [N-1:0]  t_wdata_o;
    logic          t_we_o;
    logic [3:0]    t_wstrb_o;
    logic          a_valid_o, a_ready_i, a_rvalid_i;
    logic [N-1:0]  a_rdata_i;
    logic          b_valid_o, b_ready_i, b_rvalid_i;
    logic [N-1:0]  b_rdata_i;

    bus_demux_1x2 #(.N(N), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_we_i(req_we_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .t_addr_o(t_addr_o), .t_wdata_o(t_wdata_o), .t_we_o(t_we_o), .t_wstrb_o(t_wstrb_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_rvalid_i(a_rvalid_i), .a_rdata_i(a_rdata_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_rvalid_i(b_rvalid_i), .b_rdata_i(b_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];   // {err, rdata}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && resp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_rdata_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_rdata", 64'(resp_rdata_o), 64'(e[31:0]));
                chk("resp_err",   64'(resp_err_o),   64'(e[32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 0; req_addr_i = '0; req_wdata_i = '0; req_we_i = 0; req_wstrb_i = '0;
        a_ready_i = 0; a_rvalid_i = 0; a_rdata_i = '0;
        b_ready_i = 0; b_rvalid_i = 0; b_rdata_i = '0;
    endtask

    task automatic present(input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        req_valid_i = 1; req_addr_i = addr; req_we_i = we;
        req_wdata_i = wdata; req_wstrb_i = wstrb;
    endtask

    // Minimum-latency transaction: target ready in ISSUE, response one cycle later.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic is_b,
                          input logic [31:0] rdata);
        chk({tag, "_ready_idle"}, 64'(req_ready_o), 64'd1);
        present(addr, 1'b0, 32'h0, 4'h0);
        tick();                                   // accept edge E0
        req_valid_i = 0;
        chk({tag, "_a_valid"}, 64'(a_valid_o), 64'(!is_b));
        chk({tag, "_b_valid"}, 64'(b_valid_o), 64'(is_b));
        chk({tag, "_t_addr"},  64'(t_addr_o),  64'(addr));
        if (is_b) b_ready_i = 1; else a_ready_i = 1;
        tick();                                   // E1 -> WAIT
        a_ready_i = 0; b_ready_i = 0;
        chk({tag, "_no_early_resp"}, 64'(resp_valid_o), 64'd0);
        if (is_b) begin b_rvalid_i = 1; b_rdata_i = rdata; end
        else      begin a_rvalid_i = 1; a_rdata_i = rdata; end
        exp_q.push_back({1'b0, rdata});
        tick();                                   // E2 -> RESP
        a_rvalid_i = 0; b_rvalid_i = 0;
        chk({tag, "_resp_cycle3"}, 64'(resp_valid_o), 64'd1);
        tick();                                   // E3 -> IDLE
        chk({tag, "_resp_one_cycle"}, 64'(resp_valid_o), 64'd0);
        chk({tag, "_ready_after"}, 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_i = 1;
        #12;
        // Reset state
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_valids", 64'({a_valid_o, b_valid_o, resp_valid_o}), 64'd0);
        chk("rst_resp", 64'({resp_err_o, resp_rdata_o}), 64'd0);
        chk("rst_t", 64'({t_we_o, t_wstrb_o, t_addr_o}), 64'd0);
        @(negedge clk_i);
        rst_i = 0;
        tick();

        // 1: load to A
        do_txn("t1", 32'h0000_0100, 1'b0, 32'hDEAD_BEEF);

        // 2: store to B with slow ready
        present(32'h0000_8004, 1'b1, 32'h1234_5678, 4'b0011);
        tick();
        idle_inputs();
        req_addr_i = 32'hFFFF_FFFF;               // upstream changes must not leak
        for (int i = 0; i < 4; i++) begin
            chk("t2_b_valid", 64'({a_valid_o, b_valid_o}), 64'b01);
            chk("t2_t_addr",  64'(t_addr_o),  64'h0000_8004);
            chk("t2_t_wdata", 64'(t_wdata_o), 64'h1234_5678);
            chk("t2_t_we_wstrb", 64'({t_we_o, t_wstrb_o}), 64'b10011);
            chk("t2_req_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        chk("t2_b_valid_still", 64'(b_valid_o), 64'd1);
        b_ready_i = 1;
        tick();
        b_ready_i = 0;
        chk("t2_b_valid_drop", 64'(b_valid_o), 64'd0);
        chk("t2_ready_wait", 64'(req_ready_o), 64'd0);
        b_rvalid_i = 1; b_rdata_i = 32'h0000_A5A5;
        exp_q.push_back({1'b0, 32'h0000_A5A5});
        tick();
        b_rvalid_i = 0;
        chk("t2_ready_resp", 64'(req_ready_o), 64'd0);
        tick();

        // 3: timeout on A
        present(32'h0000_0200, 1'b0, 32'h0, 4'h0);
        tick();
        req_valid_i = 0; a_ready_i = 1;
        tick();
        a_ready_i = 0;
        exp_q.push_back({1'b1, 32'h0});
        n = 0;
        while (!resp_valid_o && n < 40) begin
            tick();
            n++;
        end
        chk("t3_timeout_cycles", 64'(n), 64'd16);
        tick();
        do_txn("t3_next", 32'h0000_0300, 1'b0, 32'h0000_0011);

        // 4a: spurious A response ignored while waiting on B
        present(32'h0000_8010, 1'b0, 32'h0, 4'h0);
        tick();
        req_valid_i = 0; b_ready_i = 1;
        tick();
        b_ready_i = 0;
        a_rvalid_i = 1; a_rdata_i = 32'h0000_0BAD;
        tick();
        a_rvalid_i = 0;
        chk("t4_spurious_ignored", 64'(resp_valid_o), 64'd0);
        b_rvalid_i = 1; b_rdata_i = 32'h0000_0055;
        exp_q.push_back({1'b0, 32'h0000_0055});
        tick();
        b_rvalid_i = 0;
        tick();

        // 4b: response on the timeout cycle wins
        present(32'h0000_8020, 1'b0, 32'h0, 4'h0);
        tick();
        req_valid_i = 0; b_ready_i = 1;
        tick();
        b_ready_i = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("t4_not_timed_out", 64'(resp_valid_o), 64'd0);
        b_rvalid_i = 1; b_rdata_i = 32'h0000_0077;
        exp_q.push_back({1'b0, 32'h0000_0077});
        tick();
        b_rvalid_i = 0;
        tick();
        chk("t4_rdata_hold", 64'({resp_err_o, resp_rdata_o}), 64'h77);

        // 5: reset during WAIT
        present(32'h0000_0400, 1'b0, 32'h0, 4'h0);
        tick();
        req_valid_i = 0; a_ready_i = 1;
        tick();
        a_ready_i = 0;
        tick();
        #2 rst_i = 1;
        #1;
        chk("t5_rst_ready", 64'(req_ready_o), 64'd1);
        chk("t5_rst_valids", 64'({a_valid_o, b_valid_o, resp_valid_o}), 64'd0);
        chk("t5_rst_resp", 64'({resp_err_o, resp_rdata_o}), 64'd0);
        chk("t5_rst_t", 64'(t_addr_o), 64'd0);
        @(negedge clk_i);
        rst_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_resp", 64'(resp_valid_o), 64'd0);
        end
        do_txn("t5_a", 32'h0000_0004, 1'b0, 32'hCAFE_0001);
        do_txn("t5_b", 32'h0000_8000, 1'b1, 32'hCAFE_0002);

        tick();
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
